// File: rtl/vid_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : vid_stream_gen
// Description : Programmable raster video source. Generates the
//               pixel/de/hsync/vsync stream with front porch, sync and back
//               porch timing on both axes. Pixels come from built-in
//               patterns (colour bars, gradient, checker) or from an external
//               valid/ready pixel stream.
// Ports       : clk, rst            - pixel clock, synchronous active-high reset
//               en                  - run request (frames are never truncated)
//               mode                - 0 bars, 1 gradient, 2 checker, 3 external
//               ext_pixel_in/_valid - external {B,G,R} pixel and its valid
//               ext_ready_out       - external pixel consumed this cycle
//               pixel_out, de_out, hsync_out, vsync_out - video stream
//               sof_out             - pulse with first active pixel of a frame
//               frame_cnt_out       - count of frame starts (wrapping)
//               underrun_out        - sticky: external pixel missing
// Revision    : 1.0 - initial release
// ============================================================================
module vid_stream_gen #(
    parameter int   H_ACTIVE = 64,
    parameter int   H_FP     = 4,
    parameter int   H_SYNC   = 1,
    parameter int   H_BP     = 14,
    parameter int   V_ACTIVE = 64,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 1,
    parameter int   V_BP     = 2,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   PIX_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [3*PIX_W-1:0] ext_pixel_in,
    input  logic               ext_valid_in,
    output logic               ext_ready_out,
    output logic [3*PIX_W-1:0] pixel_out,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               sof_out,
    output logic [15:0]        frame_cnt_out,
    output logic               underrun_out
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // At least 4 bits so the checker pattern can always use bit 3.
    localparam int c_HW = ($clog2(c_H_TOTAL) > 4) ? $clog2(c_H_TOTAL) : 4;
    localparam int c_VW = ($clog2(c_V_TOTAL) > 4) ? $clog2(c_V_TOTAL) : 4;
    localparam int c_BAR_W = H_ACTIVE / 8;
    localparam int c_SEG_W = (c_BAR_W > 1) ? $clog2(c_BAR_W) : 1;

    localparam logic [c_HW-1:0]    c_H_LAST     = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0]    c_H_ACT      = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0]    c_HS_START   = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0]    c_HS_END     = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0]    c_V_LAST     = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0]    c_V_ACT      = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0]    c_VS_START   = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0]    c_VS_END     = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_SEG_W-1:0] c_SEG_LAST   = c_SEG_W'(c_BAR_W - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    localparam logic [1:0] c_MODE_BARS  = 2'd0;
    localparam logic [1:0] c_MODE_GRAD  = 2'd1;
    localparam logic [1:0] c_MODE_CHECK = 2'd2;

    logic [1:0]         r_state;
    logic [c_HW-1:0]    r_hcnt;
    logic [c_VW-1:0]    r_vcnt;
    logic [1:0]         r_mode_l;
    logic [c_SEG_W-1:0] r_seg;
    logic [2:0]         r_bar;

    logic [1:0]         w_nxt_state;
    logic [c_HW-1:0]    w_nxt_hcnt;
    logic [c_VW-1:0]    w_nxt_vcnt;
    logic [1:0]         w_nxt_mode;
    logic               w_frame_end;
    logic               w_running;
    logic               w_active;
    logic               w_nxt_active;
    logic               w_origin;
    logic [PIX_W-1:0]   w_grad;
    logic [3*PIX_W-1:0] w_pattern;

    assign w_frame_end = (r_hcnt == c_H_LAST) && (r_vcnt == c_V_LAST);
    assign w_running   = (r_state != c_ST_IDLE);
    assign w_active    = w_running && (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
    assign w_origin    = (r_hcnt == '0) && (r_vcnt == '0);

    // Next counter/state/mode values; also used to look one cycle ahead so
    // ext_ready_out is high in exactly the cycle the pixel is consumed.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_hcnt  = r_hcnt;
        w_nxt_vcnt  = r_vcnt;
        w_nxt_mode  = r_mode_l;
        case (r_state)
            c_ST_IDLE: begin
                if (en) begin
                    w_nxt_state = c_ST_RUN;
                    w_nxt_hcnt  = '0;
                    w_nxt_vcnt  = '0;
                    w_nxt_mode  = mode;
                end
            end
            default: begin
                if (w_frame_end) begin
                    w_nxt_hcnt = '0;
                    w_nxt_vcnt = '0;
                    if (en) begin
                        w_nxt_state = c_ST_RUN;
                        w_nxt_mode  = mode;
                    end else begin
                        w_nxt_state = c_ST_IDLE;
                    end
                end else begin
                    w_nxt_state = en ? c_ST_RUN : c_ST_DRAIN;
                    if (r_hcnt == c_H_LAST) begin
                        w_nxt_hcnt = '0;
                        w_nxt_vcnt = r_vcnt + 1'b1;
                    end else begin
                        w_nxt_hcnt = r_hcnt + 1'b1;
                    end
                end
            end
        endcase
    end

    assign w_nxt_active = (w_nxt_state != c_ST_IDLE) &&
                          (w_nxt_hcnt < c_H_ACT) && (w_nxt_vcnt < c_V_ACT);

    assign w_grad = PIX_W'(r_hcnt);

    // Bar colour bits {b,g,r} fall straight out of the bar index:
    // white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        w_pattern = '0;
        case (r_mode_l)
            c_MODE_BARS:  w_pattern = {{PIX_W{~r_bar[0]}}, {PIX_W{~r_bar[2]}},
                                       {PIX_W{~r_bar[1]}}};
            c_MODE_GRAD:  w_pattern = {3{w_grad}};
            c_MODE_CHECK: w_pattern = {(3*PIX_W){~(r_hcnt[3] ^ r_vcnt[3])}};
            default:      w_pattern = ext_valid_in ? ext_pixel_in : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_mode_l      <= c_MODE_BARS;
            r_seg         <= '0;
            r_bar         <= '0;
            pixel_out     <= '0;
            de_out        <= 1'b0;
            hsync_out     <= ~HS_POL;
            vsync_out     <= ~VS_POL;
            sof_out       <= 1'b0;
            ext_ready_out <= 1'b0;
            frame_cnt_out <= '0;
            underrun_out  <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_hcnt        <= w_nxt_hcnt;
            r_vcnt        <= w_nxt_vcnt;
            r_mode_l      <= w_nxt_mode;
            ext_ready_out <= w_nxt_active && (w_nxt_mode == 2'd3);

            // Segment counter tracks the bar under the next hcnt value.
            if (w_nxt_hcnt == '0) begin
                r_seg <= '0;
                r_bar <= '0;
            end else if (r_seg == c_SEG_LAST) begin
                r_seg <= '0;
                r_bar <= r_bar + 3'd1;
            end else begin
                r_seg <= r_seg + 1'b1;
            end

            if (w_running) begin
                de_out    <= w_active;
                pixel_out <= w_active ? w_pattern : '0;
                hsync_out <= ((r_hcnt >= c_HS_START) && (r_hcnt < c_HS_END)) ?
                             HS_POL : ~HS_POL;
                vsync_out <= ((r_vcnt >= c_VS_START) && (r_vcnt < c_VS_END)) ?
                             VS_POL : ~VS_POL;
                sof_out   <= w_origin;
                if (w_origin) begin
                    frame_cnt_out <= frame_cnt_out + 16'd1;
                end
                if (w_active && (r_mode_l == 2'd3) && !ext_valid_in) begin
                    underrun_out <= 1'b1;
                end
            end else begin
                de_out    <= 1'b0;
                pixel_out <= '0;
                hsync_out <= ~HS_POL;
                vsync_out <= ~VS_POL;
                sof_out   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
